sha_message_schedule: RTL
=========================

Name: sha_message_schedule

Overview:
- Sequential SHA-256 message-schedule and round-constant generator; sits directly upstream of the combinational sha_round stage.
- Accepts one 512-bit padded message block and presents W_t and K_t for t = 0..63, one round per accepted advance.
- Uses a 16-word sliding window and an internal 64-entry K ROM; the iterating core feeds Wt/Kt straight into sha_round.

Parameters:
none (SHA-256 fixed: 64 rounds, 32-bit words)

Ports:
clk       input   1    rising-edge clock
reset_n   input   1    asynchronous active-low reset
start     input   1    load block_in and begin schedule; honoured only when busy=0
block_in  input   512  padded block; word 0 = block_in[511:480], word 15 = block_in[31:0]
advance   input   1    consumer has used the current round; honoured only when valid=1
busy      output  1    schedule in progress
valid     output  1    Wt/Kt/round hold the current round's values
round     output  6    current round index t
Wt        output  32   message schedule word W_t
Kt        output  32   SHA-256 round constant K_t
done      output  1    one-cycle pulse after round 63 is advanced

Behaviour:
- Reset, asynchronous on reset_n low, and the IDLE state: busy=0, valid=0, done=0, round=0, Wt=0, Kt=0, window cleared.
- Reset mid-run aborts the schedule immediately; no done pulse is produced.
- States: IDLE -> RUN -> IDLE.
- IDLE, start=1 at a clock edge:
  - window[k] <= word k of block_in, k = 0..15.
  - round <= 0; busy and valid go to 1 on that edge, so output latency is 1 cycle.
- RUN outputs:
  - Wt = window[0].
  - Kt = KROM[round], combinational from the registered round.
  - At round t, window[k] = W_{t+k}.
- RUN with advance=1:
  - window[k] <= window[k+1] for k = 0..14.
  - window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32.
  - round <= round+1.
- RUN with advance=0: all outputs and state held; stalls may be indefinite.
- Round functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- Rounds 0..15 output the loaded words unmodified. Words computed after round 47 are never output; they are don't-care internally.
- RUN, round=63, advance=1: next edge gives valid=0, busy=0, done=1 for exactly one cycle, round=0, state IDLE.
- start while busy=1 is ignored and the window is not disturbed.
- start in the done cycle (IDLE) is accepted, giving back-to-back blocks with one idle cycle between round 63 and the new round 0.
- advance while valid=0 is ignored.
- start and advance together in IDLE: start is taken, advance is ignored.
- KROM holds the standard 64 FIPS 180-4 constants: K0=428a2f98, K1=71374491, …, K63=c67178f2.
- All arithmetic is 32-bit and wraps modulo 2^32.

Test Plan:
- Reset: assert reset_n=0 mid-run at round 20 -> busy=0, valid=0, round=0, Wt=0, Kt=0 asynchronously; no done pulse.
- "abc" block, i.e. 61626380 followed by fourteen 00000000 words then 00000018, with advance held 1:
  - t=0: Wt=61626380, Kt=428a2f98.
  - t=1: Kt=71374491.
  - t=15: Wt=00000018.
  - t=16: Wt=61626380.
  - t=17: Wt=000f0000.
  - t=63: Kt=c67178f2.
  - done pulses once, 64 cycles after valid first rises.
- Stall: same block with advance=0 for 5 cycles at t=17 -> Wt stays 000f0000, round stays 17, Kt stays KROM[17]=efbe4786; resume continues to t=18 correctly.
- start pulse at t=30 with a different block_in -> ignored; the remaining Wt sequence matches the golden "abc" schedule.
- Back-to-back: start in the done cycle with all-zero block -> valid=1 next edge, Wt=00000000 for all 64 rounds, Kt sequence restarts at 428a2f98.
- Integration: drive sha_round from Wt/Kt with initial H state 6a09e667…5be0cd19 -> round-0 output 5d6aebcd_6a09e667_bb67ae85_3c6ef372_fa2a4622_510e527f_9b05688c_1f83d9ab.

Source files
------------

// File: rtl/sha_message_schedule.sv
// SHA-256 message schedule and round-constant source: loads one 512-bit block and
// steps W_t / K_t for t = 0..63 on each accepted advance, feeding sha_round directly.
module sha_message_schedule (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic         advance,
    output logic         busy,
    output logic         valid,
    output logic [5:0]   round,
    output logic [31:0]  Wt,
    output logic [31:0]  Kt,
    output logic         done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q;
    logic        busy_q, valid_q, done_q;
    logic [5:0]  round_q;
    logic [31:0] win_q [16];
    logic [31:0] w_new_d;
    logic [31:0] kt_d;

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    function automatic logic [31:0] krom(input logic [5:0] idx);
        logic [31:0] k;
        case (idx)
            6'd0:  k = 32'h428a2f98;  6'd1:  k = 32'h71374491;
            6'd2:  k = 32'hb5c0fbcf;  6'd3:  k = 32'he9b5dba5;
            6'd4:  k = 32'h3956c25b;  6'd5:  k = 32'h59f111f1;
            6'd6:  k = 32'h923f82a4;  6'd7:  k = 32'hab1c5ed5;
            6'd8:  k = 32'hd807aa98;  6'd9:  k = 32'h12835b01;
            6'd10: k = 32'h243185be;  6'd11: k = 32'h550c7dc3;
            6'd12: k = 32'h72be5d74;  6'd13: k = 32'h80deb1fe;
            6'd14: k = 32'h9bdc06a7;  6'd15: k = 32'hc19bf174;
            6'd16: k = 32'he49b69c1;  6'd17: k = 32'hefbe4786;
            6'd18: k = 32'h0fc19dc6;  6'd19: k = 32'h240ca1cc;
            6'd20: k = 32'h2de92c6f;  6'd21: k = 32'h4a7484aa;
            6'd22: k = 32'h5cb0a9dc;  6'd23: k = 32'h76f988da;
            6'd24: k = 32'h983e5152;  6'd25: k = 32'ha831c66d;
            6'd26: k = 32'hb00327c8;  6'd27: k = 32'hbf597fc7;
            6'd28: k = 32'hc6e00bf3;  6'd29: k = 32'hd5a79147;
            6'd30: k = 32'h06ca6351;  6'd31: k = 32'h14292967;
            6'd32: k = 32'h27b70a85;  6'd33: k = 32'h2e1b2138;
            6'd34: k = 32'h4d2c6dfc;  6'd35: k = 32'h53380d13;
            6'd36: k = 32'h650a7354;  6'd37: k = 32'h766a0abb;
            6'd38: k = 32'h81c2c92e;  6'd39: k = 32'h92722c85;
            6'd40: k = 32'ha2bfe8a1;  6'd41: k = 32'ha81a664b;
            6'd42: k = 32'hc24b8b70;  6'd43: k = 32'hc76c51a3;
            6'd44: k = 32'hd192e819;  6'd45: k = 32'hd6990624;
            6'd46: k = 32'hf40e3585;  6'd47: k = 32'h106aa070;
            6'd48: k = 32'h19a4c116;  6'd49: k = 32'h1e376c08;
            6'd50: k = 32'h2748774c;  6'd51: k = 32'h34b0bcb5;
            6'd52: k = 32'h391c0cb3;  6'd53: k = 32'h4ed8aa4a;
            6'd54: k = 32'h5b9cca4f;  6'd55: k = 32'h682e6ff3;
            6'd56: k = 32'h748f82ee;  6'd57: k = 32'h78a5636f;
            6'd58: k = 32'h84c87814;  6'd59: k = 32'h8cc70208;
            6'd60: k = 32'h90befffa;  6'd61: k = 32'ha4506ceb;
            6'd62: k = 32'hbef9a3f7;  6'd63: k = 32'hc67178f2;
            default: k = 32'h0;
        endcase
        return k;
    endfunction

    // window[k] holds W_{t+k}; the new tail word is W_{t+16}
    always_comb begin
        w_new_d = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
    end

    // K is forced to zero outside a run so idle outputs read all-zero
    always_comb begin
        kt_d = '0;
        if (valid_q) kt_d = krom(round_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            round_q <= '0;
            for (int k = 0; k < 16; k++) win_q[k] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < 16; k++) win_q[k] <= block_in[511-32*k -: 32];
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (advance) begin
                        if (round_q == 6'd63) begin
                            // window is cleared so Wt reads zero once idle
                            for (int k = 0; k < 16; k++) win_q[k] <= '0;
                            round_q <= '0;
                            busy_q  <= 1'b0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            for (int k = 0; k < 15; k++) win_q[k] <= win_q[k+1];
                            win_q[15] <= w_new_d;
                            round_q   <= round_q + 6'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign done  = done_q;
    assign round = round_q;
    assign Wt    = win_q[0];
    assign Kt    = kt_d;

endmodule
